mouse_receiver: RTL and testbench
=================================

MOUSE_RECEIVER -- requirements
Module: mouse_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000, meaning max CLK cycles allowed between PS/2 clock falling edges inside a frame (100 us at 50 MHz).
REQ-002 SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port CLK_MOUSE_IN  input  1  PS/2 clock line, asynchronous to CLK.
REQ-005 SHALL have port DATA_MOUSE_IN  input  1  PS/2 data line, asynchronous to CLK.
REQ-006 SHALL have port READ_ENABLE  input  1  from master SM; high permits a new frame to start.
REQ-007 SHALL have port BYTE_READ  output  8  last received data byte.
REQ-008 SHALL have port BYTE_ERROR_CODE  output  2  bit0 = parity error, bit1 = stop-bit error.
REQ-009 SHALL have port BYTE_READY  output  1  one-cycle pulse, frame complete.

Function
REQ-010 SHALL pass CLK_MOUSE_IN and DATA_MOUSE_IN through 2-flop synchronisers of equal depth, plus one history flop on the clock path.
REQ-011 SHALL detect a PS/2 falling edge when the history flop is 1 and the synchronised clock is 0; all bit sampling uses synchronised data in that detecting cycle only.
REQ-012 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: on falling edge with READ_ENABLE=1 and data=0 (start bit) -> DATA, bit counter cleared; falling edge with data=1 or READ_ENABLE=0 -> stay IDLE.
REQ-014 DATA: on each falling edge shift data into byte LSB first; after 8th bit -> PARITY.
REQ-015 PARITY: on falling edge capture parity bit -> STOP.
REQ-016 STOP: on falling edge capture stop bit; latch BYTE_READ and BYTE_ERROR_CODE; -> IDLE.
REQ-017 Parity SHALL be odd: BYTE_ERROR_CODE[0]=1 when data bits plus parity bit contain an even number of ones.
REQ-018 BYTE_ERROR_CODE[1] SHALL be 1 when the captured stop bit is 0.
REQ-019 BYTE_READY SHALL be high for exactly one CLK cycle, the cycle after the stop-bit detecting cycle, with BYTE_READ/BYTE_ERROR_CODE already valid in that cycle.
REQ-020 BYTE_READ and BYTE_ERROR_CODE SHALL hold their values until the next completed frame.
REQ-021 A byte with errors SHALL still be latched and BYTE_READY pulsed; the master decides.
REQ-022 READ_ENABLE falling mid-frame SHALL NOT abort the frame.
REQ-023 A 16-bit timeout counter SHALL clear on every falling edge and in IDLE, and increment each cycle in DATA/PARITY/STOP.
REQ-024 Counter reaching TIMEOUT_CYCLES SHALL force IDLE with no BYTE_READY and no change to BYTE_READ/BYTE_ERROR_CODE.
REQ-025 Falling edge and timeout in the same cycle: the edge SHALL win.

Reset
REQ-026 RESET high SHALL force IDLE, BYTE_READ=0x00, BYTE_ERROR_CODE=2'b00, BYTE_READY=0, bit and timeout counters 0, synchroniser and history flops 1 (lines idle high).
REQ-027 RESET mid-frame SHALL discard the partial frame with no BYTE_READY.

Verification
REQ-028 READ_ENABLE=1, frame start0, 0xFA LSB first, parity 1, stop 1 -> one BYTE_READY pulse, BYTE_READ=0xFA, code 2'b00.
REQ-029 Frame 0xAA, parity 0, stop 1 -> BYTE_READY pulse, BYTE_READ=0xAA, code 2'b01.
REQ-030 Frame 0x00, parity 1, stop 0 -> BYTE_READY pulse, BYTE_READ=0x00, code 2'b10.
REQ-031 READ_ENABLE=0 for a whole 0xF4 frame -> no BYTE_READY, outputs unchanged.
REQ-032 Clock stopped after 4 data bits for >TIMEOUT_CYCLES -> IDLE, no pulse; following 0xF4 frame (parity 0) -> BYTE_READ=0xF4, code 2'b00.
REQ-033 RESET pulsed after bit 5 of a frame -> outputs 0; next 0xFA frame received with code 2'b00.

Source files
------------

// File: rtl/mouse_receiver.sv
// PS/2 mouse frame receiver: samples the device clock/data lines, decodes one
// 11-bit frame (start, 8 data LSB first, odd parity, stop) and pulses BYTE_READY.
module mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [1:0]  clk_sync;
  logic [1:0]  data_sync;
  logic        clk_hist;
  logic [1:0]  state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        parity_bit;
  logic [15:0] timeout_cnt;

  logic        falling;
  logic        data_bit;

  assign falling  = clk_hist & ~clk_sync[1];
  assign data_bit = data_sync[1];

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_hist  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], CLK_MOUSE_IN};
      data_sync <= {data_sync[0], DATA_MOUSE_IN};
      clk_hist  <= clk_sync[1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= IDLE;
      bit_cnt         <= 4'd0;
      shift_reg       <= 8'h00;
      parity_bit      <= 1'b0;
      timeout_cnt     <= 16'd0;
      BYTE_READ       <= 8'h00;
      BYTE_ERROR_CODE <= 2'b00;
      BYTE_READY      <= 1'b0;
    end else begin
      BYTE_READY <= 1'b0;
      if (state == IDLE) begin
        timeout_cnt <= 16'd0;
        if (falling && READ_ENABLE && !data_bit) begin
          state   <= DATA;
          bit_cnt <= 4'd0;
        end
      end else if (falling) begin
        // An edge always wins over a simultaneous timeout.
        timeout_cnt <= 16'd0;
        case (state)
          DATA: begin
            shift_reg <= {data_bit, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_bit;
            state      <= STOP;
          end
          default: begin
            BYTE_READ          <= shift_reg;
            BYTE_ERROR_CODE[0] <= ~^{shift_reg, parity_bit};
            BYTE_ERROR_CODE[1] <= ~data_bit;
            BYTE_READY         <= 1'b1;
            state              <= IDLE;
          end
        endcase
      end else if (timeout_cnt >= TIMEOUT_LIMIT) begin
        state       <= IDLE;
        timeout_cnt <= 16'd0;
      end else begin
        timeout_cnt <= timeout_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mouse_receiver.sv
// Directed bench for mouse_receiver: drives PS/2 frames and checks the latched
// byte, error code and number of BYTE_READY cycles against hand-computed values.
module tb_mouse_receiver;

  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_mouse = 1'b1;
  logic       data_mouse = 1'b1;
  logic       read_enable = 1'b1;
  logic [7:0] byte_read;
  logic [1:0] byte_error_code;
  logic       byte_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_cycles = 0;
  logic [7:0] read_at_pulse = 8'h00;
  logic [1:0] code_at_pulse = 2'b00;

  mouse_receiver #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK            (clk),
    .RESET          (reset),
    .CLK_MOUSE_IN   (clk_mouse),
    .DATA_MOUSE_IN  (data_mouse),
    .READ_ENABLE    (read_enable),
    .BYTE_READ      (byte_read),
    .BYTE_ERROR_CODE(byte_error_code),
    .BYTE_READY     (byte_ready)
  );

  always #5 clk = ~clk;

  // Outputs are sampled on the falling CLK edge, away from the active edge.
  always @(negedge clk) begin
    if (byte_ready) begin
      ready_cycles  <= ready_cycles + 1;
      read_at_pulse <= byte_read;
      code_at_pulse <= byte_error_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(posedge clk);
    data_mouse = b;
    repeat (5) @(posedge clk);
    clk_mouse = 1'b0;
    repeat (10) @(posedge clk);
    clk_mouse = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  // Sends start bit plus the first n_data data bits only.
  task automatic send_partial(input logic [7:0] b, input int n_data);
    ps2_bit(1'b0);
    for (int i = 0; i < n_data; i++) ps2_bit(b[i]);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input logic drop_re);
    ps2_bit(1'b0);
    if (drop_re) read_enable = 1'b0;
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stp);
    data_mouse = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic start_test;
    @(posedge clk);
    ready_cycles = 0;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_byte", {24'h0, byte_read}, 32'h00);
    check("reset_code", {30'h0, byte_error_code}, 32'h0);
    check("reset_ready", {31'h0, byte_ready}, 32'h0);

    // 0xFA: six ones + parity 1 = odd, stop 1
    start_test();
    send_frame(8'hFA, 1'b1, 1'b1, 1'b0);
    check("fa_pulses", ready_cycles, 1);
    check("fa_byte_at_pulse", {24'h0, read_at_pulse}, 32'hFA);
    check("fa_code_at_pulse", {30'h0, code_at_pulse}, 32'h0);
    check("fa_byte_hold", {24'h0, byte_read}, 32'hFA);

    // 0xAA: four ones + parity 0 = even -> parity error
    start_test();
    send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
    check("aa_pulses", ready_cycles, 1);
    check("aa_byte", {24'h0, read_at_pulse}, 32'hAA);
    check("aa_code", {30'h0, code_at_pulse}, 32'h1);

    // 0x00 with parity 1 is fine, stop bit 0 -> stop error
    start_test();
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    check("00_pulses", ready_cycles, 1);
    check("00_byte", {24'h0, read_at_pulse}, 32'h00);
    check("00_code", {30'h0, code_at_pulse}, 32'h2);

    // READ_ENABLE low for the whole frame: ignored, outputs held
    start_test();
    read_enable = 1'b0;
    send_frame(8'hF4, 1'b0, 1'b1, 1'b0);
    read_enable = 1'b1;
    check("re0_pulses", ready_cycles, 0);
    check("re0_byte", {24'h0, byte_read}, 32'h00);
    check("re0_code", {30'h0, byte_error_code}, 32'h2);

    // Clock stalls after 4 data bits past the timeout, then a clean 0xF4
    start_test();
    send_partial(8'hF4, 4);
    repeat (TIMEOUT + 50) @(posedge clk);
    check("to_pulses_stall", ready_cycles, 0);
    check("to_byte_stall", {24'h0, byte_read}, 32'h00);
    send_frame(8'hF4, 1'b0, 1'b1, 1'b0);
    check("to_pulses", ready_cycles, 1);
    check("to_byte", {24'h0, read_at_pulse}, 32'hF4);
    check("to_code", {30'h0, code_at_pulse}, 32'h0);

    // Reset after data bit 5 discards the frame and clears outputs
    start_test();
    send_partial(8'h3C, 5);
    @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_byte", {24'h0, byte_read}, 32'h00);
    check("rst_code", {30'h0, byte_error_code}, 32'h0);
    check("rst_pulses", ready_cycles, 0);
    start_test();
    send_frame(8'hFA, 1'b1, 1'b1, 1'b0);
    check("rst_fa_pulses", ready_cycles, 1);
    check("rst_fa_byte", {24'h0, read_at_pulse}, 32'hFA);
    check("rst_fa_code", {30'h0, code_at_pulse}, 32'h0);

    // READ_ENABLE drops right after the start bit: frame still completes
    start_test();
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    read_enable = 1'b1;
    check("redrop_pulses", ready_cycles, 1);
    check("redrop_byte", {24'h0, read_at_pulse}, 32'h55);
    check("redrop_code", {30'h0, code_at_pulse}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
